// File: rtl/alu_error_reporter.sv
// alu_error_reporter
// Latches the first ULA error (divide by zero, unused opcode, negative
// subtraction) and blinks LEDR9 until the operator acknowledges it with a
// debounced pushbutton press. It also counts latched errors, saturating at 15.
//
// Ports:
//   clk        system clock (single domain)
//   reset      synchronous active-high reset
//   exec       one-cycle strobe: seletor/b/sub_neg valid, operation committed
//   seletor    ULA operation select (001 sub, 110 div, 111 unused)
//   b          second operand
//   sub_neg    subtraction result is negative
//   key_ack_n  raw asynchronous pushbutton, active-low
//   ledr9      error LED (blinks while an error is latched)
//   err_code   latched cause: 00 none, 01 div0, 10 unused op, 11 neg sub
//   err_count  errors latched since reset, saturating at 15
//   busy       high while an error is latched
module alu_error_reporter #(
   parameter int BLINK_DIV       = 25_000_000,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       exec,
   input  logic [2:0] seletor,
   input  logic [3:0] b,
   input  logic       sub_neg,
   input  logic       key_ack_n,
   output logic       ledr9,
   output logic [1:0] err_code,
   output logic [3:0] err_count,
   output logic       busy
);

   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ERROR = 1'b1
   } state_t;

   logic          key_meta_r;
   logic          key_sync_r;
   logic          key_deb_r;
   logic          key_deb_d_r;
   logic [DW-1:0] deb_cnt_r;
   logic          ack_press_r;

   state_t        state_r;
   logic [BW-1:0] blink_cnt_r;
   logic          ledr9_r;
   logic [1:0]    err_code_r;
   logic [3:0]    err_count_r;
   logic          busy_r;

   logic          err_cond_s;
   logic [1:0]    err_cause_s;
   logic          err_hit_s;
   logic          load_s;

   // Error decode; the three conditions are disjoint by seletor.
   always_comb begin
      err_cond_s  = 1'b0;
      err_cause_s = 2'b00;
      case (seletor)
         3'b110: begin
            if (b == 4'b0000) begin
               err_cond_s  = 1'b1;
               err_cause_s = 2'b01;
            end else begin
               err_cond_s  = 1'b0;
               err_cause_s = 2'b00;
            end
         end
         3'b111: begin
            err_cond_s  = 1'b1;
            err_cause_s = 2'b10;
         end
         3'b001: begin
            if (sub_neg) begin
               err_cond_s  = 1'b1;
               err_cause_s = 2'b11;
            end else begin
               err_cond_s  = 1'b0;
               err_cause_s = 2'b00;
            end
         end
         default: begin
            err_cond_s  = 1'b0;
            err_cause_s = 2'b00;
         end
      endcase
   end

   assign err_hit_s = exec & err_cond_s;
   // A new error is latched from IDLE, or in ERROR when it coincides with an ack.
   assign load_s    = err_hit_s & ((state_r == ST_IDLE) | ack_press_r);

   // Key synchronizer, debouncer and registered press pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_meta_r  <= 1'b1;
         key_sync_r  <= 1'b1;
         key_deb_r   <= 1'b1;
         key_deb_d_r <= 1'b1;
         deb_cnt_r   <= '0;
         ack_press_r <= 1'b0;
      end else begin
         key_meta_r  <= key_ack_n;
         key_sync_r  <= key_meta_r;
         key_deb_d_r <= key_deb_r;
         // Pulse one cycle after the debounced level falls; release is ignored.
         ack_press_r <= key_deb_d_r & ~key_deb_r;
         if (key_sync_r != key_deb_r) begin
            if (deb_cnt_r == DEB_LAST) begin
               key_deb_r <= key_sync_r;
               deb_cnt_r <= '0;
            end else begin
               deb_cnt_r <= deb_cnt_r + DW'(1);
            end
         end else begin
            deb_cnt_r <= '0;
         end
      end
   end

   // Error FSM with registered LED, cause, counter and busy outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         blink_cnt_r <= '0;
         ledr9_r     <= 1'b0;
         err_code_r  <= 2'b00;
         err_count_r <= 4'h0;
         busy_r      <= 1'b0;
      end else if (load_s) begin
         state_r     <= ST_ERROR;
         blink_cnt_r <= '0;
         ledr9_r     <= 1'b1;
         err_code_r  <= err_cause_s;
         err_count_r <= (err_count_r == 4'hF) ? 4'hF : err_count_r + 4'h1;
         busy_r      <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r <= ST_IDLE;
            end
            ST_ERROR: begin
               if (ack_press_r) begin
                  state_r     <= ST_IDLE;
                  blink_cnt_r <= '0;
                  ledr9_r     <= 1'b0;
                  err_code_r  <= 2'b00;
                  busy_r      <= 1'b0;
               end else if (blink_cnt_r == BLINK_LAST) begin
                  blink_cnt_r <= '0;
                  ledr9_r     <= ~ledr9_r;
               end else begin
                  blink_cnt_r <= blink_cnt_r + BW'(1);
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               blink_cnt_r <= '0;
               ledr9_r     <= 1'b0;
               err_code_r  <= 2'b00;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign ledr9     = ledr9_r;
   assign err_code  = err_code_r;
   assign err_count = err_count_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_alu_error_reporter.sv
module tb_alu_error_reporter;

   localparam int BD = 4;
   localparam int DC = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       exec = 1'b0;
   logic [2:0] seletor = 3'b000;
   logic [3:0] b = 4'h0;
   logic       sub_neg = 1'b0;
   logic       key_ack_n = 1'b1;
   logic       ledr9;
   logic [1:0] err_code;
   logic [3:0] err_count;
   logic       busy;

   alu_error_reporter #(.BLINK_DIV(BD), .DEBOUNCE_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .exec(exec), .seletor(seletor), .b(b),
      .sub_neg(sub_neg), .key_ack_n(key_ack_n), .ledr9(ledr9),
      .err_code(err_code), .err_count(err_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural reference model ----------------
   int  cyc = 0;
   bit  m_err = 1'b0;
   int  m_code = 0;
   int  m_count = 0;
   int  m_entry = 0;
   bit  kh1 = 1'b1, kh2 = 1'b1;   // raw key samples from the last two edges
   bit  m_deb = 1'b1;
   int  run = 0;
   int  ack_at = -100;            // edge at which the acknowledge takes effect
   bit  chk_en = 1'b0;
   bit  m_sp, m_ack, exp_led;
   int  m_c;

   function automatic int cause_of();
      if (!exec) return 0;
      if (seletor == 3'b110 && b == 4'h0) return 1;
      if (seletor == 3'b111) return 2;
      if (seletor == 3'b001 && sub_neg) return 3;
      return 0;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_err = 1'b0; m_code = 0; m_count = 0;
         kh1 = 1'b1; kh2 = 1'b1; m_deb = 1'b1; run = 0; ack_at = -100;
      end else begin
         m_ack = (cyc == ack_at);
         m_c   = cause_of();
         // synchronized level seen by the debouncer = key sampled two edges ago
         m_sp = kh2; kh2 = kh1; kh1 = key_ack_n;
         if (m_sp != m_deb) begin
            run++;
            if (run == DC) begin
               run = 0;
               if (m_deb && !m_sp) ack_at = cyc + 2;
               m_deb = m_sp;
            end
         end else begin
            run = 0;
         end
         if (m_c != 0 && (!m_err || m_ack)) begin
            m_err = 1'b1; m_code = m_c; m_entry = cyc;
            m_count = (m_count < 15) ? m_count + 1 : 15;
         end else if (m_err && m_ack) begin
            m_err = 1'b0; m_code = 0;
         end
      end
      #1;
      if (chk_en) begin
         exp_led = m_err && (((cyc - m_entry) / BD) % 2 == 0);
         check("model", {ledr9, err_code, err_count, busy},
               {exp_led, m_code[1:0], m_count[3:0], m_err});
      end
   end

   // ---------------- directed + random stimulus ----------------
   int hold = 0;

   initial begin
      // 1. reset
      tick(2);
      check("rst_led", ledr9, 0);
      check("rst_code", err_code, 0);
      check("rst_count", err_count, 0);
      check("rst_busy", busy, 0);
      chk_en = 1'b1;
      reset = 1'b0;
      tick(1);

      // 2. divide by zero and blink
      exec = 1'b1; seletor = 3'b110; b = 4'h0;
      tick(1);
      exec = 1'b0;
      check("div_code", err_code, 1);
      check("div_busy", busy, 1);
      check("div_count", err_count, 1);
      check("div_led", ledr9, 1);
      for (int k = 1; k < 12; k++) begin
         tick(1);
         check("blink", ledr9, ((k / 4) % 2 == 0) ? 1 : 0);
      end

      // 3. non-errors and held errors
      exec = 1'b1; seletor = 3'b110; b = 4'h3;
      tick(1);
      seletor = 3'b001; sub_neg = 1'b0;
      tick(1);
      seletor = 3'b111;
      tick(1);
      exec = 1'b0;
      check("held_code", err_code, 1);
      check("held_count", err_count, 1);

      // 4. bounce, then real acknowledge
      key_ack_n = 1'b0; tick(2); key_ack_n = 1'b1; tick(8);
      check("bounce_busy", busy, 1);
      key_ack_n = 1'b0;
      tick(6);
      check("ack_early_busy", busy, 1);
      tick(1);
      check("ack_busy", busy, 0);
      check("ack_code", err_code, 0);
      check("ack_led", ledr9, 0);
      key_ack_n = 1'b1; tick(8);
      exec = 1'b1; seletor = 3'b001; sub_neg = 1'b1;
      tick(1);
      exec = 1'b0; sub_neg = 1'b0;
      check("neg_code", err_code, 3);
      check("neg_count", err_count, 2);

      // 5. ack coincident with a new error
      key_ack_n = 1'b0; tick(6);
      exec = 1'b1; seletor = 3'b111;
      tick(1);
      exec = 1'b0;
      check("sim_busy", busy, 1);
      check("sim_code", err_code, 2);
      check("sim_count", err_count, 3);
      check("sim_led", ledr9, 1);
      key_ack_n = 1'b1; tick(8);

      // 6. saturation, then reset mid-blink and mid-debounce
      for (int i = 0; i < 16; i++) begin
         key_ack_n = 1'b0; tick(8); key_ack_n = 1'b1; tick(8);
         exec = 1'b1; seletor = 3'b111;
         tick(1);
         exec = 1'b0;
      end
      check("sat_count", err_count, 15);
      key_ack_n = 1'b0; tick(3);
      reset = 1'b1; tick(1);
      check("mid_rst_led", ledr9, 0);
      check("mid_rst_code", err_code, 0);
      check("mid_rst_count", err_count, 0);
      check("mid_rst_busy", busy, 0);
      reset = 1'b0;
      tick(10);
      key_ack_n = 1'b1; tick(8);

      // 7. randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         reset   = ($urandom_range(0, 399) == 0);
         exec    = ($urandom_range(0, 2) == 0);
         seletor = 3'($urandom_range(0, 7));
         b       = 4'($urandom_range(0, 3));
         sub_neg = 1'($urandom_range(0, 1));
         if (hold == 0) begin
            key_ack_n = ~key_ack_n;
            hold = $urandom_range(1, 12);
         end else begin
            hold--;
         end
         tick(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
